seg7_scan_driver: RTL

- Parametrised successor to the single-digit BCD decoder: drives a DIGITS-wide multiplexed common-anode 7-segment display from an unsigned binary value.
- Contains a sequential binary-to-BCD converter (shift-add-3 / double dabble), a display latch, a refresh divider and a digit scanner.
- Sits between any datapath value and the board display pins; one instance per display bank.

---
 rtl/seg7_scan_driver.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed common-anode 7-segment display driver. A binary value is
// converted to BCD with a sequential shift-add-3 converter, committed to a
// display latch in one step, and scanned one digit at a time.
//
// Handshake: load is a request that is accepted only on a rising clk edge
// where ready=1; while ready=0 load is ignored (no queuing). ready drops the
// cycle after acceptance and returns when the converted value is visible in
// the display latch.
//
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank digits above the most
// significant non-zero digit (digit 0 is always shown; overflow dashes win).
module seg7_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int BIN_WIDTH = 14,
    parameter int CLK_DIV   = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIN_WIDTH-1:0] bin_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 ovf,
    output logic [DIGITS-1:0]    an,
    output logic [6:0]           seg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Largest value representable in DIGITS decimal digits.
    function automatic logic [63:0] max_decimal(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_decimal(DIGITS);

    // Active-low segment pattern for one BCD nibble; non-BCD shows blank.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 state;
    logic [BIN_WIDTH-1:0]   sh_bin;
    logic [BCD_W-1:0]       bcd;
    logic [BCD_W-1:0]       bcd_adj;
    logic [CNT_W-1:0]       cnt;
    logic                   ovf_pending;
    logic [BCD_W-1:0]       disp;
    logic [63:0]            bin_ext;

    logic [DIV_W-1:0]       div;
    logic [DIV_W-1:0]       div_next;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_next;
    logic [IDX_W-1:0]       msd;
    logic [3:0]             digit;
    logic                   blank;
    logic [6:0]             seg_next;
    logic [DIGITS-1:0]      an_next;

    assign bin_ext = 64'(bin_in);

    // Add-3 correction: every BCD nibble of 5 or more gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM: capture, BIN_WIDTH shift steps, then a single-cycle commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sh_bin      <= '0;
            bcd         <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            disp        <= '0;
            ovf         <= 1'b0;
            ready       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sh_bin      <= bin_in;
                        bcd         <= '0;
                        ovf_pending <= (bin_ext > MAX_VAL);
                        cnt         <= CNT_W'(BIN_WIDTH - 1);
                        ready       <= 1'b0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Bits leaving the top of the BCD register are dropped;
                    // that only happens for values already flagged as overflow.
                    bcd    <= {bcd_adj[BCD_W-2:0], sh_bin[BIN_WIDTH-1]};
                    sh_bin <= sh_bin << 1;
                    if (cnt == '0) begin
                        state <= COMMIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                COMMIT: begin
                    disp  <= bcd;
                    ovf   <= ovf_pending;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Next scan position and the segment/anode pattern for that position.
    always_comb begin
        div_next = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + 1'b1;
        idx_next = idx;
        if (div == DIV_W'(CLK_DIV - 1)) begin
            idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end

        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (disp[i*4 +: 4] != 4'd0) begin
                msd = IDX_W'(i);
            end
        end

        digit = disp[4*int'(idx_next) +: 4];

`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx_next > msd);
`else
        blank = 1'b0;
`endif

        if (ovf) begin
            seg_next = SEG_DASH;
        end else if (blank) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = decode(digit);
        end

        an_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx_next) begin
                an_next[i] = 1'b0;
            end
        end
    end

    // Refresh divider and digit scanner; an and seg register on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
            an  <= {{(DIGITS-1){1'b1}}, 1'b0};
            seg <= 7'b0000001;
        end else begin
            div <= div_next;
            idx <= idx_next;
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
